// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default constants for the 16-bit pipelined core.
package cpu_pkg;

  localparam int ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    FLUSH,
    HALT,
    EXC
  } pc_state_e;

  localparam addr_t DEF_RESET_VEC = 16'h0000;
  localparam addr_t DEF_EXC_VEC   = 16'h0002;
  localparam int    DEF_PC_INC    = 2;

  // Sequential fetch address; wraps modulo 2^16.
  function automatic addr_t pc_step(input addr_t pc, input addr_t inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: holds a redirect target that arrived while instruction memory
// was not ready, until the sequencer applies it on the next ready cycle.
module pc_redirect_hold
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_target,
  input  logic              clear,
  output logic              vld,
  output logic [ADDR_W-1:0] target
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= 1'b0;
      target <= '0;
    end else if (set) begin
      vld    <= 1'b1;
      target <= set_target;
    end else if (clear) begin
      vld    <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select, redirect flush strobes and halt control for the PC register.
// Exception support (EXC state, epc, EXC_VEC redirect) is built only with `define PC_SEQ_EXC_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter addr_t RESET_VEC    = DEF_RESET_VEC,
  parameter int    PC_INC       = DEF_PC_INC,
  parameter int    FLUSH_CYCLES = 2,
  parameter addr_t EXC_VEC      = DEF_EXC_VEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              imem_ready,
  input  logic              stall_req,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              exc_req,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              halted,
  output logic [ADDR_W-1:0] epc
);

  localparam addr_t     INC        = addr_t'(PC_INC);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  // With a single flush cycle there is nothing left to hold after the redirect itself.
  localparam pc_state_e REDIR_ST   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  pc_state_e  state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       halted_q;
  logic       exc;
  logic       pend_vld, pend_set, pend_clr;
  addr_t      pend_tgt, pend_tgt_in;
  addr_t      pc_next_c;
  logic       pc_write_c, epc_load;

  pc_redirect_hold u_hold (
    .clk       (clk),
    .rst       (rst),
    .set       (pend_set),
    .set_target(pend_tgt_in),
    .clear     (pend_clr),
    .vld       (pend_vld),
    .target    (pend_tgt)
  );

  always_comb begin
    pc_next_c   = pc_step(pc_cur, INC);
    pc_write_c  = 1'b0;
    if_id_flush = (state == FLUSH);
    id_ex_flush = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    pend_tgt_in = branch_target;
    epc_load    = 1'b0;

    if (state == FLUSH) begin
      cnt_nxt = cnt - 2'd1;
      if (cnt <= 2'd1) state_nxt = RUN;
    end

    if (state == BOOT) begin
      pc_next_c  = RESET_VEC;
      pc_write_c = 1'b1;
      state_nxt  = RUN;
    end else if (imem_ready) begin
      if (exc) begin
        epc_load    = 1'b1;
        pc_next_c   = EXC_VEC;
        pc_write_c  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pend_clr    = 1'b1;
        state_nxt   = REDIR_ST;
        cnt_nxt     = FLUSH_LOAD;
      end else if (pend_vld) begin
        // Flushes already went out when the redirect arrived.
        pc_next_c  = pend_tgt;
        pc_write_c = 1'b1;
        pend_clr   = 1'b1;
        state_nxt  = REDIR_ST;
        cnt_nxt    = FLUSH_LOAD;
      end else if (branch_req && state != HALT) begin
        pc_next_c   = branch_target;
        pc_write_c  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nxt   = REDIR_ST;
        cnt_nxt     = FLUSH_LOAD;
      end else if (state == HALT) begin
        if (resume) begin
          pc_write_c = 1'b1;
          state_nxt  = RUN;
        end
      end else if (halt_req) begin
        state_nxt = HALT;
      end else if (stall_req) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write_c = 1'b1;
      end
    end else begin
      if (exc) begin
        epc_load    = 1'b1;
        pend_set    = 1'b1;
        pend_tgt_in = EXC_VEC;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nxt   = EXC;
      end else if (branch_req && !pend_vld && state != HALT && state != EXC) begin
        pend_set    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (state == HALT) begin
        if (resume) state_nxt = RUN;
      end else if (halt_req && state != EXC) begin
        state_nxt = HALT;
      end else if (stall_req && state != EXC) begin
        id_ex_flush = 1'b1;
      end
    end
  end

  assign pc_next  = pc_next_c;
  assign pc_write = pc_write_c & rst;
  assign halted   = halted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      cnt      <= '0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      halted_q <= (state_nxt == HALT);
    end
  end

`ifdef PC_SEQ_EXC_EN
  addr_t epc_q;

  assign exc = exc_req;
  assign epc = epc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          epc_q <= '0;
    else if (epc_load) epc_q <= pc_cur;
  end
`else
  logic unused_exc;

  assign exc        = 1'b0;
  assign epc        = '0;
  assign unused_exc = ^{exc_req, EXC_VEC, epc_load};
`endif

endmodule
